// File: rtl/can_pkg.sv
// Shared widths, state encoding and frame payload type for the CAN transmit path.
package can_pkg;

  localparam int unsigned CAN_ID_W       = 11;
  localparam int unsigned CAN_DLC_W      = 4;
  localparam int unsigned CAN_DATA_W     = 64;
  localparam int unsigned CAN_IDLE_BITS  = 11;
  localparam int unsigned CAN_IDLE_CNT_W = 4;
  localparam int unsigned CAN_RETRY_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PICK = 2'd1,
    ST_WAIT = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [CAN_ID_W-1:0]   id;
    logic [CAN_DLC_W-1:0]  dlc;
    logic [CAN_DATA_W-1:0] data;
  } can_frame_t;

  // Index width for n mailboxes, never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/can_prio_pick.sv
// Combinational CAN-priority picker: lowest ID among pending entries, ties to lowest index.
module can_prio_pick
  import can_pkg::*;
#(
  parameter int unsigned NMB   = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [NMB-1:0]          pending,
  input  logic [NMB*CAN_ID_W-1:0] ids,
  output logic [SEL_W-1:0]        sel,
  output logic                    any_valid
);

  logic [CAN_ID_W-1:0] best_id;
  logic [CAN_ID_W-1:0] cur_id;

  // Strict less-than keeps the earlier (lower) index on equal IDs.
  always_comb begin
    best_id   = '1;
    cur_id    = '0;
    sel       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NMB; i++) begin
      cur_id = ids[i*CAN_ID_W +: CAN_ID_W];
      if (pending[i] && (!any_valid || (cur_id < best_id))) begin
        any_valid = 1'b1;
        best_id   = cur_id;
        sel       = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit scheduler: arbitrates mailboxes by ID, waits for bus idle, drives the frame engine.
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int unsigned NMB       = 4,
  parameter int unsigned RETRY_MAX = 8,
  parameter int unsigned IDLE_BITS = CAN_IDLE_BITS
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      bit_req,
  input  logic                      bit_rbit,
  input  logic [NMB-1:0]            mb_valid,
  input  logic [NMB-1:0]            mb_abort,
  input  logic [NMB*CAN_ID_W-1:0]   mb_id,
  input  logic [NMB*CAN_DLC_W-1:0]  mb_dlc,
  input  logic [NMB*CAN_DATA_W-1:0] mb_data,
  output logic [NMB-1:0]            mb_done,
  output logic [NMB-1:0]            mb_fail,
  output logic                      eng_start,
  output logic [CAN_ID_W-1:0]       eng_id,
  output logic [CAN_DLC_W-1:0]      eng_dlc,
  output logic [CAN_DATA_W-1:0]     eng_data,
  input  logic                      eng_done,
  input  logic                      eng_ok,
  input  logic                      eng_arb_lost,
  input  logic                      eng_err,
  output logic                      busy
);

  localparam int unsigned SEL_W = sel_width(NMB);

  sched_state_t              state;
  logic [SEL_W-1:0]          sel;
  logic [NMB-1:0]            sel_oh;
  logic [NMB-1:0]            valid_q;
  logic                      armed;
  logic [NMB-1:0]            rise;
  logic [NMB-1:0]            pending;
  logic [NMB-1:0]            pending_n;
  logic [NMB-1:0]            inflight;
  logic [NMB-1:0]            pick_mask;
  logic [NMB-1:0]            done_n;
  logic [NMB-1:0]            fail_n;
  logic [CAN_RETRY_W-1:0]    retry   [NMB];
  logic [CAN_RETRY_W-1:0]    retry_n [NMB];
  logic [CAN_RETRY_W-1:0]    retry_sel;
  logic [CAN_RETRY_W-1:0]    retry_inc;
  logic [CAN_IDLE_CNT_W-1:0] idle_cnt;
  logic                      bus_idle;
  logic                      abort_latch;
  logic                      abort_sel;
  logic [SEL_W-1:0]          pick_sel;
  logic                      pick_any;
  can_frame_t                pick_frame;
  can_frame_t                frame_q;

  assign eng_id    = frame_q.id;
  assign eng_dlc   = frame_q.dlc;
  assign eng_data  = frame_q.data;
  assign bus_idle  = (idle_cnt >= CAN_IDLE_CNT_W'(IDLE_BITS));
  assign rise      = mb_valid & ~valid_q & {NMB{armed}};
  assign inflight  = (state == ST_WAIT) ? sel_oh : '0;
  assign pick_mask = pending & ~mb_abort;
  assign abort_sel = |(mb_abort & sel_oh);
  assign retry_inc = retry_sel + CAN_RETRY_W'(1);

  // Decode the in-flight index and fetch its retry count.
  always_comb begin
    sel_oh    = '0;
    retry_sel = '0;
    for (int i = 0; i < NMB; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_oh[i] = 1'b1;
        retry_sel = retry[i];
      end
    end
  end

  can_prio_pick #(
    .NMB   (NMB),
    .SEL_W (SEL_W)
  ) u_pick (
    .pending   (pick_mask),
    .ids       (mb_id),
    .sel       (pick_sel),
    .any_valid (pick_any)
  );

  // Gather the winning mailbox's fields for latching in PICK.
  always_comb begin
    pick_frame = '0;
    for (int i = 0; i < NMB; i++) begin
      if (pick_sel == SEL_W'(i)) begin
        pick_frame.id   = mb_id[i*CAN_ID_W +: CAN_ID_W];
        pick_frame.dlc  = mb_dlc[i*CAN_DLC_W +: CAN_DLC_W];
        pick_frame.data = mb_data[i*CAN_DATA_W +: CAN_DATA_W];
      end
    end
  end

  // Mailbox bookkeeping: new requests, idle aborts and completion outcome.
  always_comb begin
    pending_n = pending | rise;
    retry_n   = retry;
    done_n    = '0;
    fail_n    = '0;
    for (int i = 0; i < NMB; i++) begin
      if (mb_abort[i] && !inflight[i]) begin
        fail_n[i]    = pending[i];
        pending_n[i] = 1'b0;
      end
    end
    if ((state == ST_WAIT) && eng_done) begin
      for (int i = 0; i < NMB; i++) begin
        if (sel_oh[i]) begin
          if (eng_ok) begin
            done_n[i]    = 1'b1;
            pending_n[i] = 1'b0;
            retry_n[i]   = '0;
          end else if (abort_latch || mb_abort[i]) begin
            fail_n[i]    = 1'b1;
            pending_n[i] = 1'b0;
            retry_n[i]   = '0;
          end else if (eng_err || !eng_arb_lost) begin
            if ((RETRY_MAX != 0) && (retry_inc == CAN_RETRY_W'(RETRY_MAX))) begin
              fail_n[i]    = 1'b1;
              pending_n[i] = 1'b0;
              retry_n[i]   = '0;
            end else begin
              retry_n[i] = retry_inc;
            end
          end
        end
      end
    end
  end

  // Mailbox state registers; armed masks the first post-reset cycle so held valids are not new requests.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      armed   <= 1'b0;
      pending <= '0;
      mb_done <= '0;
      mb_fail <= '0;
      for (int i = 0; i < NMB; i++) begin
        retry[i] <= '0;
      end
    end else begin
      valid_q <= mb_valid;
      armed   <= 1'b1;
      pending <= pending_n;
      mb_done <= done_n;
      mb_fail <= fail_n;
      retry   <= retry_n;
    end
  end

  // Bus idle detector: saturating count of consecutive recessive bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (eng_done) begin
      idle_cnt <= '0;
    end else if (bit_req) begin
      if (!bit_rbit) begin
        idle_cnt <= '0;
      end else if (idle_cnt < CAN_IDLE_CNT_W'(IDLE_BITS)) begin
        idle_cnt <= idle_cnt + CAN_IDLE_CNT_W'(1);
      end
    end
  end

  // Scheduler FSM with registered engine handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      sel         <= '0;
      frame_q     <= '0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
      abort_latch <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if ((|pending) && bus_idle) begin
            state <= ST_PICK;
          end
        end
        ST_PICK: begin
          if (pick_any) begin
            sel         <= pick_sel;
            frame_q     <= pick_frame;
            eng_start   <= 1'b1;
            busy        <= 1'b1;
            abort_latch <= 1'b0;
            state       <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            busy        <= 1'b0;
            abort_latch <= 1'b0;
            state       <= ST_IDLE;
          end else if (abort_sel) begin
            abort_latch <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
